// File: rtl/vga_plot_arbiter.sv
// rtl/vga_plot_arbiter.sv - round-robin arbiter sharing the framebuffer pixel-write port
module vga_plot_arbiter #(
  parameter int NREQ     = 3,
  parameter int XW       = 8,
  parameter int YW       = 8,
  parameter int CW       = 12,
  parameter int XMAX     = 159,
  parameter int YMAX     = 119,
  parameter int PRIO0    = 1,
  parameter int HOLD_MAX = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*XW-1:0] req_x,
  input  logic [NREQ*YW-1:0] req_y,
  input  logic [NREQ*CW-1:0] req_color,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    ack,
  input  logic               plot_ready,
  output logic               plot,
  output logic [XW-1:0]      plot_x,
  output logic [YW-1:0]      plot_y,
  output logic [14:0]        plot_addr,
  output logic [CW-1:0]      plot_color,
  output logic [2:0]         owner,
  output logic               busy,
  output logic [7:0]         oob_count
);

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_REL} state_t;

  localparam logic [31:0] XLIM = XMAX;
  localparam logic [31:0] YLIM = YMAX;
  localparam logic [31:0] XDIM = XMAX + 1;

  state_t           state_q, state_d;
  logic [2:0]       owner_q, owner_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [15:0]      hold_q, hold_d;
  logic             plot_q;
  logic [XW-1:0]    x_q;
  logic [YW-1:0]    y_q;
  logic [14:0]      addr_q;
  logic [CW-1:0]    color_q;
  logic [7:0]       oob_q;

  logic [NREQ-1:0]   grant_w;
  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [3:0]        win_sum;
  logic [2:0]        win;
  logic              own_req, other_req, accept, on_screen;
  logic [XW-1:0]     sel_x;
  logic [YW-1:0]     sel_y;
  logic [CW-1:0]     sel_c;
  logic [14:0]       addr_w;

  // Winner select: fixed priority for requester 0, else first request at/after the pointer
  always_comb begin
    req_dbl = {req, req};
    req_rot = NREQ'(req_dbl >> ptr_q);
    win_sum = 4'd0;
    win     = ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        win_sum = 4'(ptr_q) + 4'(k);
        win     = (win_sum >= 4'(NREQ)) ? 3'(win_sum - 4'(NREQ)) : 3'(win_sum);
      end
    end
    if (PRIO0 != 0 && req[0]) win = 3'd0;
  end

  // Grant decode and owner's pixel mux; grant comes only from registered state
  always_comb begin
    grant_w = '0;
    sel_x   = '0;
    sel_y   = '0;
    sel_c   = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant_w[i] = (state_q == S_OWN) && (owner_q == 3'(i));
      if (grant_w[i]) begin
        sel_x = sel_x | req_x[i*XW +: XW];
        sel_y = sel_y | req_y[i*YW +: YW];
        sel_c = sel_c | req_color[i*CW +: CW];
      end
    end
    own_req   = |(req & grant_w);
    other_req = |(req & ~grant_w);
    accept    = (|(req_valid & grant_w)) && plot_ready;
    on_screen = (32'(sel_x) <= XLIM) && (32'(sel_y) <= YLIM);
    addr_w    = 15'(32'(sel_y) * XDIM + 32'(sel_x));
  end

  // Next-state logic for ownership, hold count and round-robin pointer
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          owner_d = win;
          state_d = S_OWN;
        end
      end
      S_OWN: begin
        if (accept && HOLD_MAX != 0 && hold_q != 16'(HOLD_MAX)) hold_d = hold_q + 16'd1;
        if (!own_req ||
            (HOLD_MAX != 0 && hold_q == 16'(HOLD_MAX) && other_req && !accept))
          state_d = S_REL;
      end
      S_REL: begin
        ptr_d   = (owner_q == 3'(NREQ - 1)) ? 3'd0 : owner_q + 3'd1;
        hold_d  = 16'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Arbitration state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= 3'd0;
      ptr_q   <= 3'd0;
      hold_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  // Pixel output registers; off-screen pixels are swallowed and counted
  always_ff @(posedge clk) begin
    if (reset) begin
      plot_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      color_q <= '0;
      oob_q   <= 8'd0;
    end else begin
      plot_q <= accept && on_screen;
      if (accept && on_screen) begin
        x_q     <= sel_x;
        y_q     <= sel_y;
        addr_q  <= addr_w;
        color_q <= sel_c;
      end
      if (accept && !on_screen && oob_q != 8'hFF) oob_q <= oob_q + 8'd1;
    end
  end

  assign grant      = grant_w;
  assign ack        = accept ? grant_w : '0;
  assign plot       = plot_q;
  assign plot_x     = x_q;
  assign plot_y     = y_q;
  assign plot_addr  = addr_q;
  assign plot_color = color_q;
  assign owner      = owner_q;
  assign busy       = (state_q == S_OWN);
  assign oob_count  = oob_q;

endmodule
